// File: rtl/logic_unit_pkg.sv
// Opcode encoding shared by the logic unit, the arbiter and anything that issues ops.
package logic_unit_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_LAST = 3'd4;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise unit: one gate per bit per function, then an opcode mux.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nand (w_nand[i], a[i], b[i]);
    not  u_not  (w_not[i],  a[i]);
    and  u_and  (w_and[i],  a[i], b[i]);
    or   u_or   (w_or[i],   a[i], b[i]);
    xor  u_xor  (w_xor[i],  a[i], b[i]);
  end

  // Illegal opcodes deliberately produce all-zero data alongside err.
  always_comb begin
    y = '0;
    case (op)
      OP_NAND: y = w_nand;
      OP_NOT:  y = w_not;
      OP_AND:  y = w_and;
      OP_OR:   y = w_or;
      OP_XOR:  y = w_xor;
      default: y = '0;
    endcase
  end

  assign err = op_illegal(op);

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter granting one requester per cycle onto a shared logic unit,
// with a single registered response slot that holds under backpressure.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int CNTW  = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [CNTW-1:0]       op_count
);

  logic [IDW-1:0]   r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic             r_err;
  logic [CNTW-1:0]  r_count;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic             w_can_accept;
  logic             w_fire;
  logic             w_done;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_err;
  logic [IDW-1:0]   w_ptr_nxt;

  // Two passes give wrap-around priority: first at/above the pointer, then below it.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
  end

  assign w_can_accept = !rst && (!r_valid || rsp_ready);
  assign w_fire       = w_can_accept && w_found;
  assign w_done       = r_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_gnt] = 1'b1;
  end

  assign w_op = req_op[int'(w_gnt)*3 +: 3];
  assign w_a  = req_a[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_b  = req_b[int'(w_gnt)*WIDTH +: WIDTH];

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op  (w_op),
    .a   (w_a),
    .b   (w_b),
    .y   (w_y),
    .err (w_err)
  );

  assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

  // Response slot: a new grant overwrites a completing response in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_fire) begin
        r_valid <= 1'b1;
        r_data  <= w_y;
        r_id    <= w_gnt;
        r_err   <= w_err;
        r_ptr   <= w_ptr_nxt;
      end else if (w_done) begin
        r_valid <= 1'b0;
      end
      if (w_done) r_count <= r_count + 1'b1;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign rsp_err   = r_err;
  assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: per-cycle reference model plus literal checks.
module tb_logic_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic [CNTW-1:0]       op_count;

  int total = 0;
  int bad   = 0;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be, from the behavioural rules.
  bit         m_init = 0;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  bit         m_err;
  int         m_cnt;
  int         m_ptr;

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return ~(a & b);
      3'd1: return ~a;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ref_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] ref_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = ref_grant();
    if (!rst && (!m_valid || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    bit acc;
    bit done;
    if (rst) begin
      m_init = 1; m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_init) begin
      g    = ref_grant();
      acc  = !m_valid || rsp_ready;
      done = m_valid && rsp_ready;
      if (done) m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (acc && g >= 0) begin
        m_valid = 1;
        m_data  = ref_op(req_op[g*3 +: 3], req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
        m_id    = g;
        m_err   = (req_op[g*3 +: 3] > 3'd4);
        m_ptr   = (g + 1) % NREQ;
      end else if (done) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("model_rsp_data",  32'(rsp_data),  32'(m_data));
      chk("model_rsp_id",    32'(rsp_id),    32'(m_id));
      chk("model_rsp_err",   32'(rsp_err),   32'(m_err));
      chk("model_op_count",  32'(op_count),  32'(m_cnt));
      chk("model_req_ready", 32'(req_ready), 32'(ref_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i*3 +: 3]         = op;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_e);
    set_req(0, op, a, b);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"},  32'(rsp_data),  32'(exp_d));
    chk({name, "_err"},   32'(rsp_err),   32'(exp_e));
    tick();
  endtask

  initial begin
    int exp_ids [5] = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = 4'b1111; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset holds everything idle even with all requesters valid
    tick();
    tick();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_op_count",  32'(op_count),  32'h0);
    rst = 1'b0; req_valid = 4'b0000;
    tick();

    // Single request, requester 2, AND
    set_req(2, 3'd2, 8'hF0, 8'h3C);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data",  32'(rsp_data),  32'h30);
    chk("single_id",    32'(rsp_id),    32'd2);
    chk("single_err",   32'(rsp_err),   32'd0);
    tick();
    chk("single_count", 32'(op_count),  32'd1);

    // Fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd4, 8'(i * 17), 8'h0F);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_id",    32'(rsp_id),   32'(exp_ids[k]));
      chk("fair_count", 32'(op_count), 32'(k));
    end
    req_valid = 4'b0000;
    tick();

    // Backpressure holds the response and blocks new grants
    rsp_ready = 1'b0;
    set_req(1, 3'd4, 8'hAA, 8'hFF);
    req_valid = 4'b0010;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(3, 3'd3, 8'h81, 8'h18);
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      chk("bp_data_hold", 32'(rsp_data),  32'h55);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_data",  32'(rsp_data),  32'h99);
    chk("bp_next_id",    32'(rsp_id),    32'd3);
    tick();

    // Opcode coverage
    do_op("op_not",     3'd1, 8'h0F, 8'h00, 8'hF0, 1'b0);
    do_op("op_nand",    3'd0, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    do_op("op_or",      3'd3, 8'h81, 8'h18, 8'h99, 1'b0);
    do_op("op_illegal", 3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1);

    // Reset while FULL drops the response and returns the pointer to 0
    rsp_ready = 1'b0;
    set_req(2, 3'd2, 8'hF0, 8'h3C);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("full_valid", 32'(rsp_valid), 32'd1);
    chk("full_id",    32'(rsp_id),    32'd2);
    rst = 1'b1;
    req_valid = 4'b0011;
    set_req(0, 3'd2, 8'hFF, 8'h0F);
    set_req(1, 3'd3, 8'h01, 8'h10);
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_id0",   32'(rsp_id),   32'd0);
    chk("post_rst_data0", 32'(rsp_data), 32'h0F);
    req_valid = 4'b0010;
    #1;
    chk("post_rst_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("post_rst_id1",   32'(rsp_id),   32'd1);
    chk("post_rst_data1", 32'(rsp_data), 32'h11);
    req_valid = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Round-robin arbiter that shares one bitwise logic unit (NAND/NOT/AND/OR/XOR over WIDTH bits) between NREQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The arbiter grants one request per cycle and registers the result with the requester id. The result is held under response backpressure. It sits between the gate-level logic datapath and the blocks that need bitwise operations.

Parameters:
NREQ, 4, number of requesters; must be at least 2; need not be a power of two.
WIDTH, 8, operand and result width in bits.
IDW, $clog2(NREQ), width of the requester id (derived; not overridden).
CNTW, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NREQ  bit i: requester i has a pending operation.
req_ready  output  NREQ  one-hot or zero; bit i: requester i's operation is accepted this cycle.
req_op  input  NREQ*3  requester i opcode at [i*3 +: 3].
req_a  input  NREQ*WIDTH  requester i operand A at [i*WIDTH +: WIDTH].
req_b  input  NREQ*WIDTH  requester i operand B at [i*WIDTH +: WIDTH].
rsp_valid  output  1  registered result is available.
rsp_ready  input  1  consumer accepts the result.
rsp_data  output  WIDTH  result.
rsp_id  output  IDW  index of the requester that produced the result.
rsp_err  output  1  the opcode was illegal.
op_count  output  CNTW  number of completed responses; wraps modulo 2^CNTW.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_count=0.
  - Round-robin pointer=0.
  - req_ready=0 while rst=1, regardless of req_valid.
- Opcodes (3 bits):
  - 0 NAND: ~(a&b)
  - 1 NOT: ~a (b ignored)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5..7 illegal: rsp_data=0, rsp_err=1.
- State is implied by rsp_valid:
  - EMPTY when rsp_valid=0.
  - FULL when rsp_valid=1.
- can_accept = !rst && (!rsp_valid || rsp_ready).
- Grant selection:
  - The grant goes to the first i with req_valid[i]=1, searching from the pointer upward with wrap-around modulo NREQ.
  - req_ready[g]=1 only if can_accept.
  - req_ready is combinational from req_valid, pointer, rsp_valid and rsp_ready.
  - Requesters must not make req_valid depend on req_ready.
- On a grant at the clock edge:
  - rsp_data <= logic_unit(op_g, a_g, b_g).
  - rsp_id <= g.
  - rsp_err <= (op_g > 4).
  - rsp_valid <= 1.
  - pointer <= (g+1) mod NREQ.
- Latency: one cycle from acceptance to rsp_valid.
- Throughput: one operation per cycle while rsp_ready=1.
- Response completion:
  - rsp_valid && rsp_ready with no new grant: rsp_valid <= 0 next cycle.
  - Completion and a new grant in the same cycle: rsp_valid stays 1 and the new data replaces the old.
- Backpressure: rsp_valid=1 && rsp_ready=0 → rsp_data, rsp_id and rsp_err are held stable, and req_ready=0.
- op_count increments by 1 on every cycle with rsp_valid && rsp_ready. It wraps to 0 after 2^CNTW-1.
- No valid request: the pointer is unchanged and req_ready=0.
- Requester protocol: once req_valid[i] rises, req_valid, op, a and b for requester i stay stable until req_ready[i]. Violations are not detected.
- Reset mid-operation: the pending response is dropped, rsp_valid=0 on the next cycle, and the pointer returns to 0.

Decomposition:
- Package logic_unit_pkg: opcode constants OP_NAND=3'd0, OP_NOT=3'd1, OP_AND=3'd2, OP_OR=3'd3, OP_XOR=3'd4; OP_LAST=3'd4 for the illegal-opcode check.
- Sub-module logic_unit: combinational; inputs op, a, b; outputs y and err. It is built from the existing gate primitives replicated WIDTH times, with an opcode mux.
- The arbiter contains the pointer, grant logic, response register and counter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req_valid=4'b1111 → req_ready=0, rsp_valid=0, rsp_data=0, op_count=0.
2. Single request: requester 2 only, AND, a=8'hF0, b=8'h3C, rsp_ready=1 → req_ready=4'b0100 the same cycle. Next cycle: rsp_valid=1, rsp_data=8'h30, rsp_id=2, rsp_err=0, op_count=1 after the handshake.
3. Fairness: req_valid=4'b1111 held, rsp_ready=1 → rsp_id sequence 0,1,2,3,0 on consecutive cycles; op_count increments every cycle.
4. Backpressure: XOR, a=8'hAA, b=8'hFF, rsp_ready=0 for 5 cycles → rsp_data=8'h55 stable and req_ready=0 throughout. Raise rsp_ready → the next request is granted in that same cycle and rsp_valid stays 1.
5. Opcodes: NOT a=8'h0F → 8'hF0. NAND 8'hFF,8'h0F → 8'hF0. OR 8'h81,8'h18 → 8'h99. Op 3'd6 → rsp_data=0, rsp_err=1.
6. Reset while FULL: rsp_valid=1 (id 2), assert rst for 1 cycle with req_valid=4'b0011 → rsp_valid=0. The first grant after reset is requester 0, then requester 1.
